// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
//   Bundles every non-clock, non-reset signal of the reorder buffer.
//   master : the core side (issue stage, functional units, fetch, RF writeback)
//   slave  : the reorder buffer itself
//
//   Issue / allocation
//     alloc_req, alloc_is_branch, alloc_dest_reg, alloc_target  master -> slave
//     alloc_ready, alloc_index                                   slave  -> master
//   FU result buses (FU i owns slice i of each bus)
//     data_bus, valid_bus, RB_index_bus                          master -> slave
//   Broadcast to reservation stations (entry k owns slice k)
//     CDB_data_data, CDB_data_valid                              slave  -> master
//   Retirement
//     commit_valid, commit_reg, commit_data                      slave  -> master
//     redirect_valid, redirect_pc, reset_bus                     slave  -> master
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 3,
    parameter int REG_INDEX = 5,
    parameter int FU_NUM    = 4
);
    logic                          alloc_req;
    logic                          alloc_is_branch;
    logic [REG_INDEX-1:0]          alloc_dest_reg;
    logic [WORD_SIZE-1:0]          alloc_target;
    logic                          alloc_ready;
    logic [RB_INDEX-1:0]           alloc_index;

    logic [FU_NUM*WORD_SIZE-1:0]   data_bus;
    logic [FU_NUM-1:0]             valid_bus;
    logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus;

    logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data;
    logic [RB_SIZE-1:0]            CDB_data_valid;

    logic                          commit_valid;
    logic [REG_INDEX-1:0]          commit_reg;
    logic [WORD_SIZE-1:0]          commit_data;
    logic                          redirect_valid;
    logic [WORD_SIZE-1:0]          redirect_pc;
    logic [FU_NUM-1:0]             reset_bus;

    modport master (
        output alloc_req, alloc_is_branch, alloc_dest_reg, alloc_target,
        input  alloc_ready, alloc_index,
        output data_bus, valid_bus, RB_index_bus,
        input  CDB_data_data, CDB_data_valid,
        input  commit_valid, commit_reg, commit_data,
        input  redirect_valid, redirect_pc, reset_bus
    );

    modport slave (
        input  alloc_req, alloc_is_branch, alloc_dest_reg, alloc_target,
        output alloc_ready, alloc_index,
        input  data_bus, valid_bus, RB_index_bus,
        output CDB_data_data, CDB_data_valid,
        output commit_valid, commit_reg, commit_data,
        output redirect_valid, redirect_pc, reset_bus
    );
endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Circular reorder buffer for the Tomasulo core. Issue allocates one entry
//   per dispatched instruction at the tail; functional units write results
//   into entries by tag; every ready result is re-broadcast to the reservation
//   stations; entries retire in program order from the head. A taken branch
//   at the head redirects fetch, drops every younger entry and pulses
//   reset_bus to all functional units.
//
//   Ports
//     clk    : clock
//     reset  : asynchronous, active-high; clears all state immediately
//     rb     : reorder_buffer_if.slave (allocation, FU result buses, CDB
//              broadcast, commit, redirect and reset_bus)
//
//   Timing
//     alloc_ready/alloc_index/CDB_* are combinational from registered state.
//     commit_*, redirect_* and reset_bus are registered one-cycle pulses that
//     appear after the edge on which the head entry retires.
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 3,
    parameter int REG_INDEX = 5,
    parameter int FU_NUM    = 4
) (
    input  logic             clk,
    input  logic             reset,
    reorder_buffer_if.slave  rb
);

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    logic [RB_INDEX-1:0] head_reg, head_next;
    logic [RB_INDEX-1:0] tail_reg, tail_next;
    logic [RB_INDEX:0]   count_reg, count_next;

    // ------------------------------------------------------------------
    // Flattened views of the per-entry state, driven from g_entry
    // ------------------------------------------------------------------
    logic [RB_SIZE-1:0]           busy_vec;
    logic [RB_SIZE-1:0]           ready_vec;
    logic [RB_SIZE-1:0]           branch_vec;
    logic [RB_SIZE*REG_INDEX-1:0] dest_flat;
    logic [RB_SIZE*WORD_SIZE-1:0] target_flat;
    logic [RB_SIZE*WORD_SIZE-1:0] value_flat;

    // ------------------------------------------------------------------
    // Head entry fields and retirement decisions
    // ------------------------------------------------------------------
    logic                 head_busy;
    logic                 head_ready;
    logic                 head_branch;
    logic [REG_INDEX-1:0] head_dest;
    logic [WORD_SIZE-1:0] head_target;
    logic [WORD_SIZE-1:0] head_value;

    logic commit_now;     // head retires on the coming edge
    logic flush_now;      // head is a taken branch: retire and squash all
    logic full;
    logic alloc_ready_int;
    logic alloc_fire;

    // ------------------------------------------------------------------
    // Registered pulse outputs
    // ------------------------------------------------------------------
    logic                 commit_valid_reg,   commit_valid_next;
    logic [REG_INDEX-1:0] commit_reg_reg,     commit_reg_next;
    logic [WORD_SIZE-1:0] commit_data_reg,    commit_data_next;
    logic                 redirect_valid_reg, redirect_valid_next;
    logic [WORD_SIZE-1:0] redirect_pc_reg,    redirect_pc_next;
    logic [FU_NUM-1:0]    reset_bus_reg,      reset_bus_next;

    assign head_busy   = busy_vec[head_reg];
    assign head_ready  = ready_vec[head_reg];
    assign head_branch = branch_vec[head_reg];
    assign head_dest   = dest_flat[head_reg*REG_INDEX +: REG_INDEX];
    assign head_target = target_flat[head_reg*WORD_SIZE +: WORD_SIZE];
    assign head_value  = value_flat[head_reg*WORD_SIZE +: WORD_SIZE];

    assign commit_now = head_busy && head_ready;
    assign flush_now  = commit_now && head_branch && head_value[0];

    // Full blocks allocation even when the head retires on the same edge;
    // issue simply retries next cycle. A pending flush also blocks it, since
    // anything allocated on that edge would be squashed anyway.
    assign full            = (count_reg == (RB_INDEX+1)'(RB_SIZE));
    assign alloc_ready_int = !full && !flush_now;
    assign alloc_fire      = rb.alloc_req && alloc_ready_int;

    // ------------------------------------------------------------------
    // Per-entry storage
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < RB_SIZE; gi++) begin : g_entry
        logic                 busy_reg;
        logic                 ready_reg;
        logic                 branch_reg;
        logic [REG_INDEX-1:0] dest_reg;
        logic [WORD_SIZE-1:0] target_reg;
        logic [WORD_SIZE-1:0] value_reg;

        logic                 is_head;
        logic                 is_tail;
        logic                 hit;
        logic [WORD_SIZE-1:0] hit_value;

        assign is_head = (head_reg == RB_INDEX'(gi));
        assign is_tail = (tail_reg == RB_INDEX'(gi));

        // Scan from the highest FU down so the lowest-numbered FU that
        // targets this tag overrides any others.
        always_comb begin
            hit       = 1'b0;
            hit_value = '0;
            for (int i = FU_NUM - 1; i >= 0; i--) begin
                if (rb.valid_bus[i] &&
                    rb.RB_index_bus[i*RB_INDEX +: RB_INDEX] == RB_INDEX'(gi)) begin
                    hit       = 1'b1;
                    hit_value = rb.data_bus[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end

        // Priority: flush > retire > allocate > capture. Allocation only
        // ever targets a free entry (the tail when not full), so it never
        // collides with retirement or capture of a busy entry.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                busy_reg   <= 1'b0;
                ready_reg  <= 1'b0;
                branch_reg <= 1'b0;
                dest_reg   <= '0;
                target_reg <= '0;
                value_reg  <= '0;
            end else if (flush_now) begin
                busy_reg   <= 1'b0;
                ready_reg  <= 1'b0;
            end else if (commit_now && is_head) begin
                busy_reg   <= 1'b0;
                ready_reg  <= 1'b0;
            end else if (alloc_fire && is_tail) begin
                busy_reg   <= 1'b1;
                ready_reg  <= 1'b0;
                branch_reg <= rb.alloc_is_branch;
                dest_reg   <= rb.alloc_dest_reg;
                target_reg <= rb.alloc_target;
            end else if (busy_reg && hit) begin
                value_reg  <= hit_value;
                ready_reg  <= 1'b1;
            end
        end

        assign busy_vec[gi]                              = busy_reg;
        assign ready_vec[gi]                             = ready_reg;
        assign branch_vec[gi]                            = branch_reg;
        assign dest_flat[gi*REG_INDEX +: REG_INDEX]      = dest_reg;
        assign target_flat[gi*WORD_SIZE +: WORD_SIZE]    = target_reg;
        assign value_flat[gi*WORD_SIZE +: WORD_SIZE]     = value_reg;
    end

    // ------------------------------------------------------------------
    // Pointer / occupancy next state
    // ------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_now) begin
            // The taken branch itself retires; everything younger is gone,
            // so the buffer restarts empty just past the branch.
            head_next  = head_reg + 1'b1;
            tail_next  = head_reg + 1'b1;
            count_next = '0;
        end else begin
            if (alloc_fire) begin
                tail_next = tail_reg + 1'b1;
            end
            if (commit_now) begin
                head_next = head_reg + 1'b1;
            end
            case ({alloc_fire, commit_now})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Retirement pulses. commit_reg/commit_data/redirect_pc hold their
    // last value between pulses; only the *_valid strobes carry meaning.
    // ------------------------------------------------------------------
    always_comb begin
        commit_valid_next   = commit_now && !head_branch;
        commit_reg_next     = commit_reg_reg;
        commit_data_next    = commit_data_reg;
        redirect_valid_next = flush_now;
        redirect_pc_next    = redirect_pc_reg;
        reset_bus_next      = {FU_NUM{flush_now}};
        if (commit_valid_next) begin
            commit_reg_next  = head_dest;
            commit_data_next = head_value;
        end
        if (flush_now) begin
            redirect_pc_next = head_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_valid_reg   <= 1'b0;
            commit_reg_reg     <= '0;
            commit_data_reg    <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            reset_bus_reg      <= '0;
        end else begin
            commit_valid_reg   <= commit_valid_next;
            commit_reg_reg     <= commit_reg_next;
            commit_data_reg    <= commit_data_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
            reset_bus_reg      <= reset_bus_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rb.alloc_ready    = alloc_ready_int;
    assign rb.alloc_index    = tail_reg;
    assign rb.CDB_data_data  = value_flat;
    assign rb.CDB_data_valid = busy_vec & ready_vec;
    assign rb.commit_valid   = commit_valid_reg;
    assign rb.commit_reg     = commit_reg_reg;
    assign rb.commit_data    = commit_data_reg;
    assign rb.redirect_valid = redirect_valid_reg;
    assign rb.redirect_pc    = redirect_pc_reg;
    assign rb.reset_bus      = reset_bus_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//   Drives the reorder buffer with directed scenarios and then randomized
//   traffic. The reference model is a program-ordered queue of in-flight
//   instructions; expected outputs are derived from it on every cycle.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
    localparam int W   = 32;
    localparam int RBS = 8;
    localparam int RBI = 3;
    localparam int RGI = 5;
    localparam int FUN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI),
                        .REG_INDEX(RGI), .FU_NUM(FUN)) rb_if();

    reorder_buffer #(.WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI),
                     .REG_INDEX(RGI), .FU_NUM(FUN)) dut (
        .clk   (clk),
        .reset (reset),
        .rb    (rb_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              tag;
        bit              br;
        logic [RGI-1:0]  dest;
        logic [W-1:0]    tgt;
        bit              rdy;
        logic [W-1:0]    val;
    } ent_t;

    ent_t           q[$];        // in-flight instructions, oldest first
    int             m_tail;      // tag the next allocation receives
    bit             e_cv, e_rv;
    logic [RGI-1:0] e_creg;
    logic [W-1:0]   e_cdata, e_rpc;
    logic [FUN-1:0] e_rbus;

    function automatic bit m_flush();
        return q.size() > 0 && q[0].rdy && q[0].br && q[0].val[0];
    endfunction

    function automatic bit m_alloc_ready();
        return q.size() < RBS && !m_flush();
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        e_cv = 0; e_rv = 0; e_rbus = '0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit           can_alloc;
        bit           cap[RBS];
        logic [W-1:0] cap_val[RBS];
        int           t;
        ent_t         e;
        can_alloc = m_alloc_ready();
        e_cv = 0; e_rv = 0; e_rbus = '0;
        if (m_flush()) begin
            e_rv   = 1;
            e_rpc  = q[0].tgt;
            e_rbus = '1;
            m_tail = (q[0].tag + 1) % RBS;
            q.delete();
            return;
        end
        for (int k = 0; k < RBS; k++) begin
            cap[k] = 0;
            cap_val[k] = '0;
        end
        for (int i = 0; i < FUN; i++) begin
            if (rb_if.valid_bus[i]) begin
                t = int'(rb_if.RB_index_bus[i*RBI +: RBI]);
                if (!cap[t]) begin
                    cap[t] = 1;
                    cap_val[t] = rb_if.data_bus[i*W +: W];
                end
            end
        end
        if (q.size() > 0 && q[0].rdy) begin
            if (!q[0].br) begin
                e_cv    = 1;
                e_creg  = q[0].dest;
                e_cdata = q[0].val;
            end
            void'(q.pop_front());
        end
        foreach (q[k]) begin
            if (cap[q[k].tag]) begin
                q[k].rdy = 1;
                q[k].val = cap_val[q[k].tag];
            end
        end
        if (can_alloc && rb_if.alloc_req) begin
            e.tag  = m_tail;
            e.br   = rb_if.alloc_is_branch;
            e.dest = rb_if.alloc_dest_reg;
            e.tgt  = rb_if.alloc_target;
            e.rdy  = 0;
            e.val  = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % RBS;
        end
    endtask

    // ---------------- compare process ----------------
    logic [RBS-1:0] ev;
    logic [W-1:0]   ed[RBS];
    always @(negedge clk) begin
        if (check_en) begin
            ev = '0;
            foreach (q[k]) begin
                if (q[k].rdy) begin
                    ev[q[k].tag] = 1'b1;
                    ed[q[k].tag] = q[k].val;
                end
            end
            chk("alloc_ready", 64'(rb_if.alloc_ready), 64'(m_alloc_ready()));
            if (m_alloc_ready())
                chk("alloc_index", 64'(rb_if.alloc_index), 64'(m_tail));
            chk("cdb_valid", 64'(rb_if.CDB_data_valid), 64'(ev));
            for (int k = 0; k < RBS; k++)
                if (ev[k]) chk("cdb_data", 64'(rb_if.CDB_data_data[k*W +: W]), 64'(ed[k]));
            chk("commit_valid", 64'(rb_if.commit_valid), 64'(e_cv));
            if (e_cv) begin
                chk("commit_reg", 64'(rb_if.commit_reg), 64'(e_creg));
                chk("commit_data", 64'(rb_if.commit_data), 64'(e_cdata));
                $display("tx commit r%0d <= %08h", e_creg, e_cdata);
            end
            chk("redirect_valid", 64'(rb_if.redirect_valid), 64'(e_rv));
            if (e_rv) begin
                chk("redirect_pc", 64'(rb_if.redirect_pc), 64'(e_rpc));
                $display("tx redirect pc=%08h flush", e_rpc);
            end
            chk("reset_bus", 64'(rb_if.reset_bus), 64'(e_rbus));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_idle();
        rb_if.alloc_req       = 1'b0;
        rb_if.alloc_is_branch = 1'b0;
        rb_if.alloc_dest_reg  = '0;
        rb_if.alloc_target    = '0;
        rb_if.valid_bus       = '0;
        rb_if.data_bus        = '0;
        rb_if.RB_index_bus    = '0;
    endtask

    task automatic set_alloc(input bit br, input int dest, input logic [W-1:0] tgt);
        rb_if.alloc_req       = 1'b1;
        rb_if.alloc_is_branch = br;
        rb_if.alloc_dest_reg  = RGI'(dest);
        rb_if.alloc_target    = tgt;
    endtask

    task automatic set_fu(input int i, input int tag, input logic [W-1:0] v);
        rb_if.valid_bus[i]             = 1'b1;
        rb_if.RB_index_bus[i*RBI +: RBI] = RBI'(tag);
        rb_if.data_bus[i*W +: W]       = v;
    endtask

    // Called at negedge+1; returns at the following negedge+1.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1 set_idle();
        @(negedge clk);
        #1;
    endtask

    // Reset asserted between edges; state must clear without a clock edge.
    task automatic async_reset();
        check_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_cdb_valid", 64'(rb_if.CDB_data_valid), 64'h0);
        chk("rst_alloc_index", 64'(rb_if.alloc_index), 64'h0);
        chk("rst_alloc_ready", 64'(rb_if.alloc_ready), 64'h1);
        chk("rst_commit_valid", 64'(rb_if.commit_valid), 64'h0);
        chk("rst_reset_bus", 64'(rb_if.reset_bus), 64'h0);
        model_reset();
        set_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check_en = 1'b1;
    endtask

    // Branch at tag2 with two older and three younger instructions.
    task automatic branch_case(input bit taken);
        async_reset();
        set_alloc(0, 1, 0);        tick();
        set_alloc(0, 2, 0);        tick();
        set_alloc(1, 0, 32'h40);   tick();
        set_alloc(0, 4, 0);        tick();
        set_alloc(0, 5, 0);        tick();
        set_alloc(0, 6, 0);        tick();
        set_fu(0, 0, 32'd10); set_fu(1, 1, 32'd11); set_fu(2, 3, 32'd13); set_fu(3, 4, 32'd14);
        tick();
        set_fu(0, 5, 32'd15); set_fu(1, 2, taken ? 32'd1 : 32'd2);
        tick();
        chk("br_commit0_reg", 64'(rb_if.commit_reg), 64'd1);
        tick();
        chk("br_commit1_reg", 64'(rb_if.commit_reg), 64'd2);
        chk("br_pending_alloc_ready", 64'(rb_if.alloc_ready), taken ? 64'd0 : 64'd1);
        tick();
        if (taken) begin
            chk("tk_redirect_valid", 64'(rb_if.redirect_valid), 64'd1);
            chk("tk_redirect_pc", 64'(rb_if.redirect_pc), 64'h40);
            chk("tk_reset_bus", 64'(rb_if.reset_bus), 64'hF);
            chk("tk_cdb_valid", 64'(rb_if.CDB_data_valid), 64'h0);
            chk("tk_alloc_index", 64'(rb_if.alloc_index), 64'd3);
            tick();
            chk("tk_reset_bus_drop", 64'(rb_if.reset_bus), 64'h0);
            chk("tk_no_young_commit", 64'(rb_if.commit_valid), 64'd0);
        end else begin
            chk("nt_redirect_valid", 64'(rb_if.redirect_valid), 64'd0);
            chk("nt_silent", 64'(rb_if.commit_valid), 64'd0);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("nt_young_reg", 64'(rb_if.commit_reg), 64'(4 + k));
                chk("nt_young_data", 64'(rb_if.commit_data), 64'(13 + k));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int ap, fp;
    initial begin
        set_idle();
        repeat (2) @(negedge clk);
        chk("init_commit_reg", 64'(rb_if.commit_reg), 64'h0);
        chk("init_commit_data", 64'(rb_if.commit_data), 64'h0);
        chk("init_redirect_pc", 64'(rb_if.redirect_pc), 64'h0);
        chk("init_cdb_data", 64'(|rb_if.CDB_data_data), 64'h0);
        chk("init_alloc_ready", 64'(rb_if.alloc_ready), 64'h1);
        model_reset();
        reset = 1'b0;
        #1 check_en = 1'b1;

        // Three allocations, out-of-order completion, in-order commit
        set_alloc(0, 1, 0); tick();
        set_alloc(0, 2, 0); tick();
        set_alloc(0, 3, 0); tick();
        chk("t1_alloc_index", 64'(rb_if.alloc_index), 64'd3);
        set_fu(0, 1, 32'd7); tick();
        chk("t1_cdb_valid", 64'(rb_if.CDB_data_valid), 64'b010);
        chk("t1_cdb_data1", 64'(rb_if.CDB_data_data[1*W +: W]), 64'd7);
        tick();
        chk("t1_no_commit", 64'(rb_if.commit_valid), 64'd0);
        set_fu(1, 0, 32'd5); tick();
        chk("t2_cdb_valid", 64'(rb_if.CDB_data_valid), 64'b011);
        tick();
        chk("t2_c0_valid", 64'(rb_if.commit_valid), 64'd1);
        chk("t2_c0_reg", 64'(rb_if.commit_reg), 64'd1);
        chk("t2_c0_data", 64'(rb_if.commit_data), 64'd5);
        tick();
        chk("t2_c1_reg", 64'(rb_if.commit_reg), 64'd2);
        chk("t2_c1_data", 64'(rb_if.commit_data), 64'd7);
        tick();
        chk("t2_tag2_pending", 64'(rb_if.commit_valid), 64'd0);

        // Fill, drop while full, free one, wrap
        async_reset();
        for (int k = 0; k < RBS; k++) begin
            set_alloc(0, k + 1, 0);
            tick();
        end
        chk("t3_full", 64'(rb_if.alloc_ready), 64'd0);
        set_alloc(0, 9, 0); tick();
        chk("t3_drop_model", 64'(q.size()), 64'd8);
        set_fu(0, 0, 32'h99); tick();
        chk("t3_still_full", 64'(rb_if.alloc_ready), 64'd0);
        tick();
        chk("t3_freed", 64'(rb_if.alloc_ready), 64'd1);
        chk("t3_wrap_index", 64'(rb_if.alloc_index), 64'd0);
        chk("t3_commit_data", 64'(rb_if.commit_data), 64'h99);

        branch_case(1'b1);
        branch_case(1'b0);

        // Reset while five entries are busy
        async_reset();
        for (int k = 0; k < 5; k++) begin
            set_alloc(0, k + 10, 0);
            tick();
        end
        set_fu(0, 1, 32'd3); set_fu(1, 3, 32'd4); tick();
        chk("t6_cdb_valid", 64'(rb_if.CDB_data_valid), 64'b01010);
        async_reset();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 299) async_reset();
            case ((c / 150) % 4)
                0: begin ap = 90; fp = 20; end
                1: begin ap = 40; fp = 70; end
                2: begin ap = 70; fp = 50; end
                default: begin ap = 95; fp = 5; end
            endcase
            if ($urandom_range(0, 99) < ap)
                set_alloc($urandom_range(0, 9) == 0, int'($urandom_range(0, 31)), $urandom());
            for (int i = 0; i < FUN; i++) begin
                if ($urandom_range(0, 99) < fp) begin
                    if (q.size() > 0 && $urandom_range(0, 9) < 8)
                        set_fu(i, q[$urandom_range(0, q.size() - 1)].tag, $urandom());
                    else
                        set_fu(i, int'($urandom_range(0, RBS - 1)), $urandom());
                end
            end
            tick();
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
